l2_mem_arbiter: RTL and testbench
=================================

Name: l2_mem_arbiter

Overview:
Shares one single-port L2 SRAM bank between two masters:
- the JTAG debug bus master (dbg_), which issues the write32/read32 bursts driven through the PULP TAP;
- the system-side master (sys_).

The block performs address decode, alignment/range checking, round-robin arbitration with a bounded burst lock, and routes the 1-cycle-latency SRAM read response back to the owning master. It sits between the debug-bus/interconnect ports and the L2 SRAM macro.

Parameters:
- ADDR_WIDTH, 32, master address width (byte addresses).
- DATA_WIDTH, 32, data width; byte enables are DATA_WIDTH/8.
- MEM_ADDR_WIDTH, 10, SRAM word-address width; NUM_WORDS = 2**MEM_ADDR_WIDTH.
- BASE_ADDR, 32'h1C00_0000, byte address of SRAM word 0.
- MAX_HOLD, 16, maximum consecutive grants to a locked master while the other master is requesting.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous active-high reset.
- dbg_req_i, sys_req_i  in  1  access request, held until granted.
- dbg_gnt_o, sys_gnt_o  out  1  request accepted this cycle.
- dbg_addr_i, sys_addr_i  in  ADDR_WIDTH  byte address.
- dbg_we_i, sys_we_i  in  1  1 = write.
- dbg_be_i, sys_be_i  in  DATA_WIDTH/8  byte enables.
- dbg_wdata_i, sys_wdata_i  in  DATA_WIDTH  write data.
- dbg_lock_i, sys_lock_i  in  1  burst lock request.
- dbg_rvalid_o, sys_rvalid_o  out  1  response valid.
- dbg_rdata_o, sys_rdata_o  out  DATA_WIDTH  read data.
- dbg_err_o, sys_err_o  out  1  response error, qualified by rvalid.
- mem_req_o  out  1  SRAM access enable.
- mem_we_o  out  1  SRAM write enable.
- mem_addr_o  out  MEM_ADDR_WIDTH  SRAM word address.
- mem_be_o  out  DATA_WIDTH/8  SRAM byte enables.
- mem_wdata_o  out  DATA_WIDTH  SRAM write data.
- mem_rdata_i  in  DATA_WIDTH  SRAM read data, valid 1 cycle after mem_req_o.

Behaviour:
- Reset (rst_i=1, async):
  - all gnt/rvalid/err/mem_* outputs 0; rdata outputs 0;
  - FSM = RR, last_owner = SYS, hold_cnt = 0;
  - any pending response is dropped and never delivered.
- Grant timing:
  - gnt is combinational from req and the registered arbitration state, in the same cycle.
  - At most one gnt per cycle.
  - The memory access is issued in the grant cycle.
- Response:
  - rvalid is asserted exactly 1 cycle after gnt, to the granted master only, for both reads and writes.
  - For reads, rdata = mem_rdata_i; for writes, rdata = 0.
  - A new grant may be issued in the same cycle as the previous response (full throughput, 1 access/cycle).
- Decode:
  - off = addr - BASE_ADDR.
  - err when addr < BASE_ADDR, off >= 4*NUM_WORDS, or addr[1:0] != 0.
  - An error access is still granted, mem_req_o stays 0, and the next cycle returns rvalid=1, err=1, rdata=0.
  - Otherwise mem_addr_o = off[MEM_ADDR_WIDTH+1:2].
- FSM states RR, LOCK_DBG, LOCK_SYS:
  - RR, single requester: that master is granted.
  - RR, both requesting: the master != last_owner is granted; last_owner is updated on every grant.
  - RR, granted request has lock_i=1: go to LOCK_<m> with hold_cnt=1.
  - LOCK_m: only m may be granted; the other master's gnt is forced to 0.
    - Each grant to m increments hold_cnt.
    - lock_i of m = 0 in any cycle: go to RR with last_owner=m. If m requests in that cycle, that request is granted under RR rules.
    - hold_cnt == MAX_HOLD and the other master is requesting: go to RR with last_owner=m, so the other master wins the next cycle; m must re-lock.
    - hold_cnt saturates at MAX_HOLD when the other master is idle; the lock continues.
- Simultaneous events:
  - Lock assertion by both masters in RR: the round-robin winner locks.
  - A request plus lock drop in the same cycle: the request is served unlocked.
- rst_i asserted mid-burst: the burst is abandoned and no response is issued. The master must reissue it.

Decomposition:
- Package l2_arb_pkg:
  - arb_state_e (RR, LOCK_DBG, LOCK_SYS);
  - master_id_e (DBG, SYS);
  - default MAX_HOLD constant;
  - hold-counter width function.
- Sub-module l2_addr_decode (combinational): addr in, word address and err out; instantiated once on the muxed address.

Test Plan:
- Reset, then dbg writes 0xABBAABBA to 0x1C00_0000 and reads it back -> 1 gnt per access, rvalid 1 cycle later, read rdata=0xABBAABBA, err=0; mem_addr_o=0.
- dbg and sys request every cycle, no lock -> grants alternate DBG, SYS, DBG, ... (DBG first after reset); each rvalid goes only to its owner.
- dbg holds lock for 40 back-to-back reads while sys requests continuously, MAX_HOLD=16 -> 16 dbg grants, 1 sys grant, dbg re-locks, 16 more dbg grants; sys never starves for more than 16 cycles.
- Access to 0x1C00_1000 (out of range), 0x1BFF_FFFC and 0x1C00_0002 -> gnt=1, mem_req_o=0, next-cycle rvalid=1, err=1, rdata=0.
- Write with be=4'b0011, data 0x1234_5678 over a word holding 0xFFFF_FFFF, then read -> 0xFFFF_5678.
- rst_i pulsed in the cycle after a read grant -> no rvalid is delivered; FSM returns to RR; the next simultaneous request is granted to DBG.

Source files
------------

// File: rtl/l2_arb_pkg.sv
// Shared types and constants for the L2 SRAM two-master arbiter.
package l2_arb_pkg;

  typedef enum logic [1:0] {
    RR       = 2'd0,
    LOCK_DBG = 2'd1,
    LOCK_SYS = 2'd2
  } arb_state_e;

  typedef enum logic {
    DBG = 1'b0,
    SYS = 1'b1
  } master_id_e;

  localparam int unsigned DEF_MAX_HOLD = 16;

  // Bits needed to count 0..max_hold inclusive.
  function automatic int unsigned hold_cnt_width(input int unsigned max_hold);
    return (max_hold < 1) ? 1 : $clog2(max_hold + 1);
  endfunction

endpackage

// File: rtl/l2_addr_decode.sv
// Byte address -> SRAM word address, with range and alignment error flag.
module l2_addr_decode
  import l2_arb_pkg::*;
#(
  parameter int unsigned             ADDR_WIDTH     = 32,
  parameter int unsigned             MEM_ADDR_WIDTH = 10,
  parameter logic [ADDR_WIDTH-1:0]   BASE_ADDR      = 32'h1C00_0000
) (
  input  logic [ADDR_WIDTH-1:0]     i_addr,
  output logic [MEM_ADDR_WIDTH-1:0] o_waddr,
  output logic                      o_err
);

  // BASE_ADDR is word-aligned, so the offset is computed on word bits only.
  localparam logic [ADDR_WIDTH-3:0] BASE_WORD = BASE_ADDR[ADDR_WIDTH-1:2];

  logic [ADDR_WIDTH-3:0] w_off_w;
  logic                  w_below;
  logic                  w_over;
  logic                  w_misalign;

  // Offset, bounds and alignment checks.
  always_comb begin
    w_off_w    = i_addr[ADDR_WIDTH-1:2] - BASE_WORD;
    w_below    = (i_addr < BASE_ADDR);
    w_over     = |w_off_w[ADDR_WIDTH-3:MEM_ADDR_WIDTH];
    w_misalign = |i_addr[1:0];
    o_err      = w_below | w_over | w_misalign;
    o_waddr    = w_off_w[MEM_ADDR_WIDTH-1:0];
  end

endmodule

// File: rtl/l2_mem_arbiter.sv
// Two-master (debug / system) arbiter in front of a single-port L2 SRAM bank.
// Round-robin with a bounded burst lock; 1-cycle response routed to the owner.
module l2_mem_arbiter
  import l2_arb_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH     = 32,
  parameter int unsigned           DATA_WIDTH     = 32,
  parameter int unsigned           MEM_ADDR_WIDTH = 10,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = 32'h1C00_0000,
  parameter int unsigned           MAX_HOLD       = DEF_MAX_HOLD
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      dbg_req_i,
  output logic                      dbg_gnt_o,
  input  logic [ADDR_WIDTH-1:0]     dbg_addr_i,
  input  logic                      dbg_we_i,
  input  logic [DATA_WIDTH/8-1:0]   dbg_be_i,
  input  logic [DATA_WIDTH-1:0]     dbg_wdata_i,
  input  logic                      dbg_lock_i,
  output logic                      dbg_rvalid_o,
  output logic [DATA_WIDTH-1:0]     dbg_rdata_o,
  output logic                      dbg_err_o,
  input  logic                      sys_req_i,
  output logic                      sys_gnt_o,
  input  logic [ADDR_WIDTH-1:0]     sys_addr_i,
  input  logic                      sys_we_i,
  input  logic [DATA_WIDTH/8-1:0]   sys_be_i,
  input  logic [DATA_WIDTH-1:0]     sys_wdata_i,
  input  logic                      sys_lock_i,
  output logic                      sys_rvalid_o,
  output logic [DATA_WIDTH-1:0]     sys_rdata_o,
  output logic                      sys_err_o,
  output logic                      mem_req_o,
  output logic                      mem_we_o,
  output logic [MEM_ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH/8-1:0]   mem_be_o,
  output logic [DATA_WIDTH-1:0]     mem_wdata_o,
  input  logic [DATA_WIDTH-1:0]     mem_rdata_i
);

  localparam int unsigned       HOLD_W   = hold_cnt_width(MAX_HOLD);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);

  arb_state_e              r_state;
  master_id_e              r_last;
  logic [HOLD_W-1:0]       r_hold;
  logic                    r_rsp_dbg;
  logic                    r_rsp_sys;
  logic                    r_rsp_err;
  logic                    r_rsp_rd;

  logic                    w_rel_dbg;
  logic                    w_rel_sys;
  logic                    w_eff_rr;
  master_id_e              w_eff_last;
  logic                    w_gnt_dbg;
  logic                    w_gnt_sys;
  logic                    w_any_gnt;
  logic [ADDR_WIDTH-1:0]   w_addr;
  logic                    w_we;
  logic [DATA_WIDTH/8-1:0] w_be;
  logic [DATA_WIDTH-1:0]   w_wdata;
  logic [MEM_ADDR_WIDTH-1:0] w_waddr;
  logic                    w_dec_err;
  logic                    w_mem_req;
  logic [DATA_WIDTH-1:0]   w_rdata;

  // Grant decision. A lock that is dropped or has hit its hold limit while the
  // other master waits is released in the same cycle, so this cycle is
  // arbitrated as round-robin with the locking master treated as last owner.
  always_comb begin
    w_rel_dbg  = (r_state == LOCK_DBG) &&
                 (!dbg_lock_i || ((r_hold == HOLD_MAX) && sys_req_i));
    w_rel_sys  = (r_state == LOCK_SYS) &&
                 (!sys_lock_i || ((r_hold == HOLD_MAX) && dbg_req_i));
    w_eff_rr   = !(((r_state == LOCK_DBG) && !w_rel_dbg) ||
                   ((r_state == LOCK_SYS) && !w_rel_sys));
    w_eff_last = r_last;
    if (r_state == LOCK_DBG)      w_eff_last = DBG;
    else if (r_state == LOCK_SYS) w_eff_last = SYS;
    w_gnt_dbg = 1'b0;
    w_gnt_sys = 1'b0;
    if (!rst_i) begin
      if (w_eff_rr) begin
        if (dbg_req_i && sys_req_i) begin
          if (w_eff_last == DBG) w_gnt_sys = 1'b1;
          else                   w_gnt_dbg = 1'b1;
        end else begin
          w_gnt_dbg = dbg_req_i;
          w_gnt_sys = sys_req_i;
        end
      end else if (r_state == LOCK_DBG) begin
        w_gnt_dbg = dbg_req_i;
      end else begin
        w_gnt_sys = sys_req_i;
      end
    end
  end

  // Request mux towards the decoder and SRAM.
  always_comb begin
    w_any_gnt = w_gnt_dbg | w_gnt_sys;
    w_addr    = w_gnt_sys ? sys_addr_i  : dbg_addr_i;
    w_we      = w_gnt_sys ? sys_we_i    : dbg_we_i;
    w_be      = w_gnt_sys ? sys_be_i    : dbg_be_i;
    w_wdata   = w_gnt_sys ? sys_wdata_i : dbg_wdata_i;
  end

  l2_addr_decode #(
    .ADDR_WIDTH    (ADDR_WIDTH),
    .MEM_ADDR_WIDTH(MEM_ADDR_WIDTH),
    .BASE_ADDR     (BASE_ADDR)
  ) u_decode (
    .i_addr (w_addr),
    .o_waddr(w_waddr),
    .o_err  (w_dec_err)
  );

  // SRAM drive; all fields held at zero when no valid access is issued.
  always_comb begin
    w_mem_req   = w_any_gnt & ~w_dec_err;
    mem_req_o   = w_mem_req;
    mem_we_o    = w_mem_req & w_we;
    mem_addr_o  = w_mem_req ? w_waddr : '0;
    mem_be_o    = w_mem_req ? w_be    : '0;
    mem_wdata_o = w_mem_req ? w_wdata : '0;
    dbg_gnt_o   = w_gnt_dbg;
    sys_gnt_o   = w_gnt_sys;
  end

  // Arbitration state: lock entry, hold counting and round-robin history.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= RR;
      r_last  <= SYS;
      r_hold  <= '0;
    end else if (w_eff_rr) begin
      if (w_gnt_dbg) begin
        r_last  <= DBG;
        r_state <= dbg_lock_i ? LOCK_DBG : RR;
        r_hold  <= dbg_lock_i ? HOLD_W'(1) : '0;
      end else if (w_gnt_sys) begin
        r_last  <= SYS;
        r_state <= sys_lock_i ? LOCK_SYS : RR;
        r_hold  <= sys_lock_i ? HOLD_W'(1) : '0;
      end else begin
        r_last  <= w_eff_last;
        r_state <= RR;
        r_hold  <= '0;
      end
    end else if (w_any_gnt && (r_hold != HOLD_MAX)) begin
      r_hold <= r_hold + HOLD_W'(1);
    end
  end

  // Response tracking for the access issued this cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rsp_dbg <= 1'b0;
      r_rsp_sys <= 1'b0;
      r_rsp_err <= 1'b0;
      r_rsp_rd  <= 1'b0;
    end else begin
      r_rsp_dbg <= w_gnt_dbg;
      r_rsp_sys <= w_gnt_sys;
      r_rsp_err <= w_any_gnt & w_dec_err;
      r_rsp_rd  <= w_mem_req & ~w_we;
    end
  end

  // Response routing: only the owning master sees valid, error and data.
  always_comb begin
    w_rdata      = r_rsp_rd ? mem_rdata_i : '0;
    dbg_rvalid_o = r_rsp_dbg;
    sys_rvalid_o = r_rsp_sys;
    dbg_err_o    = r_rsp_dbg & r_rsp_err;
    sys_err_o    = r_rsp_sys & r_rsp_err;
    dbg_rdata_o  = r_rsp_dbg ? w_rdata : '0;
    sys_rdata_o  = r_rsp_sys ? w_rdata : '0;
  end

endmodule

// File: tb/tb_l2_mem_arbiter.sv
// Self-checking bench for l2_mem_arbiter with an SRAM model and response scoreboard.
module tb_l2_mem_arbiter;

  localparam logic [31:0] BASE = 32'h1C00_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        dbg_req, dbg_we, dbg_lock, sys_req, sys_we, sys_lock;
  logic [31:0] dbg_addr, dbg_wdata, sys_addr, sys_wdata;
  logic [3:0]  dbg_be, sys_be;
  logic        dbg_gnt, sys_gnt, dbg_rvalid, sys_rvalid, dbg_err, sys_err;
  logic [31:0] dbg_rdata, sys_rdata;
  logic        mem_req, mem_we;
  logic [9:0]  mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic [31:0] sram_rdata = '0;
  logic [31:0] sram [0:1023];
  logic        filled = 1'b0;

  typedef struct {
    logic        is_sys;
    logic        err;
    logic [31:0] data;
    int          due;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  l2_mem_arbiter #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_ADDR_WIDTH(10),
    .BASE_ADDR(32'h1C00_0000), .MAX_HOLD(16)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .dbg_req_i(dbg_req), .dbg_gnt_o(dbg_gnt), .dbg_addr_i(dbg_addr),
    .dbg_we_i(dbg_we), .dbg_be_i(dbg_be), .dbg_wdata_i(dbg_wdata),
    .dbg_lock_i(dbg_lock), .dbg_rvalid_o(dbg_rvalid), .dbg_rdata_o(dbg_rdata),
    .dbg_err_o(dbg_err),
    .sys_req_i(sys_req), .sys_gnt_o(sys_gnt), .sys_addr_i(sys_addr),
    .sys_we_i(sys_we), .sys_be_i(sys_be), .sys_wdata_i(sys_wdata),
    .sys_lock_i(sys_lock), .sys_rvalid_o(sys_rvalid), .sys_rdata_o(sys_rdata),
    .sys_err_o(sys_err),
    .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
    .mem_be_o(mem_be), .mem_wdata_o(mem_wdata), .mem_rdata_i(sram_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] pat(input int w);
    return 32'hC0DE_0000 | 32'(w);
  endfunction

  // SRAM model: prefilled with pat(), byte-enabled writes, 1-cycle read latency.
  always @(posedge clk) begin
    if (!filled) begin
      for (int i = 0; i < 1024; i++) sram[i] <= pat(i);
      filled <= 1'b1;
    end else if (mem_req) begin
      if (mem_we)
        for (int b = 0; b < 4; b++)
          if (mem_be[b]) sram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
      sram_rdata <= sram[mem_addr];
    end
  end

  // Scoreboard: each response must match the oldest expectation, on time.
  always @(negedge clk) begin
    if (dbg_rvalid === 1'b1 || sys_rvalid === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_rvalid cyc=%0d got dbg=%b sys=%b required none", cyc, dbg_rvalid, sys_rvalid);
      end else begin
        mon_e = sb.pop_front();
        if (dbg_rvalid !== !mon_e.is_sys || sys_rvalid !== mon_e.is_sys || cyc !== mon_e.due ||
            (mon_e.is_sys ? sys_err : dbg_err) !== mon_e.err ||
            (mon_e.is_sys ? sys_rdata : dbg_rdata) !== mon_e.data ||
            (mon_e.is_sys ? dbg_rdata : sys_rdata) !== 32'h0) begin
          errors++;
          $display("FAIL response cyc=%0d got rv(d/s)=%b/%b err(d/s)=%b/%b rdata(d/s)=%h/%h required sys=%b err=%b rdata=%h due=%0d",
                   cyc, dbg_rvalid, sys_rvalid, dbg_err, sys_err, dbg_rdata, sys_rdata,
                   mon_e.is_sys, mon_e.err, mon_e.data, mon_e.due);
        end
      end
    end else if (sb.size() != 0 && sb[0].due < cyc) begin
      checks++;
      errors++;
      $display("FAIL missing_rvalid cyc=%0d got none required response due %0d", cyc, sb[0].due);
      void'(sb.pop_front());
    end
  end

  task automatic set_dbg(input logic req, input logic we, input logic [31:0] addr,
                         input logic [3:0] be, input logic [31:0] wd, input logic lock);
    dbg_req = req; dbg_we = we; dbg_addr = addr; dbg_be = be; dbg_wdata = wd; dbg_lock = lock;
  endtask

  task automatic set_sys(input logic req, input logic we, input logic [31:0] addr,
                         input logic [3:0] be, input logic [31:0] wd, input logic lock);
    sys_req = req; sys_we = we; sys_addr = addr; sys_be = be; sys_wdata = wd; sys_lock = lock;
  endtask

  task automatic idle_all();
    set_dbg(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0);
    set_sys(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0);
  endtask

  task automatic push_exp(input logic is_sys, input logic err, input logic [31:0] data);
    sb.push_back('{is_sys, err, data, cyc + 1});
  endtask

  task automatic drain();
    for (int i = 0; i < 6 && sb.size() != 0; i++) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d outstanding responses required 0", sb.size());
    end
    sb.delete();
  endtask

  task automatic apply_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    idle_all();
    @(posedge clk); #1;
    rst = 1'b0;
    sb.delete();
  endtask

  task automatic test_reset();
    set_dbg(1'b1, 1'b1, BASE, 4'hF, 32'hDEAD_BEEF, 1'b1);
    set_sys(1'b1, 1'b1, BASE + 32'h10, 4'hF, 32'h1111_2222, 1'b1);
    @(negedge clk);
    checks++;
    if ({dbg_gnt, sys_gnt, dbg_rvalid, sys_rvalid, dbg_err, sys_err, mem_req, mem_we} !== 8'h00) begin
      errors++;
      $display("FAIL reset_ctrl got %b required 00000000",
               {dbg_gnt, sys_gnt, dbg_rvalid, sys_rvalid, dbg_err, sys_err, mem_req, mem_we});
    end
    checks++;
    if (mem_addr !== 10'h0 || mem_be !== 4'h0 || mem_wdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_mem got addr=%h be=%h wdata=%h required 0", mem_addr, mem_be, mem_wdata);
    end
    checks++;
    if (dbg_rdata !== 32'h0 || sys_rdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_rdata got %h/%h required 0/0", dbg_rdata, sys_rdata);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    idle_all();
  endtask

  task automatic test_dbg_write_read();
    @(posedge clk); #1;
    set_dbg(1'b1, 1'b1, BASE, 4'hF, 32'hABBA_ABBA, 1'b0);
    @(negedge clk);
    checks++;
    if ({dbg_gnt, sys_gnt, mem_req, mem_we} !== 4'b1011 || mem_addr !== 10'd0 ||
        mem_wdata !== 32'hABBA_ABBA || mem_be !== 4'hF) begin
      errors++;
      $display("FAIL dbg_write_issue got g/req/we=%b addr=%h wd=%h be=%h required 1011 0 abbaabba f",
               {dbg_gnt, sys_gnt, mem_req, mem_we}, mem_addr, mem_wdata, mem_be);
    end
    push_exp(1'b0, 1'b0, 32'h0);
    @(posedge clk); #1;
    set_dbg(1'b1, 1'b0, BASE, 4'hF, 32'h0, 1'b0);
    @(negedge clk);
    checks++;
    if ({dbg_gnt, sys_gnt, mem_req, mem_we} !== 4'b1010 || mem_addr !== 10'd0) begin
      errors++;
      $display("FAIL dbg_read_issue got %b addr=%h required 1010 addr 0", {dbg_gnt, sys_gnt, mem_req, mem_we}, mem_addr);
    end
    push_exp(1'b0, 1'b0, 32'hABBA_ABBA);
    @(posedge clk); #1;
    idle_all();
    drain();
  endtask

  task automatic test_alternate();
    int di = 0;
    int si = 0;
    logic turn_dbg = 1'b1;
    apply_reset();
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      set_dbg(1'b1, 1'b0, BASE + 32'(4 * (100 + di)), 4'hF, 32'h0, 1'b0);
      set_sys(1'b1, 1'b0, BASE + 32'(4 * (200 + si)), 4'hF, 32'h0, 1'b0);
      @(negedge clk);
      checks++;
      if (dbg_gnt !== turn_dbg || sys_gnt !== !turn_dbg ||
          mem_addr !== (turn_dbg ? 10'(100 + di) : 10'(200 + si))) begin
        errors++;
        $display("FAIL alternate k=%0d got gnt d/s=%b/%b addr=%0d required dbg_turn=%b", k, dbg_gnt, sys_gnt, mem_addr, turn_dbg);
      end
      if (turn_dbg) begin push_exp(1'b0, 1'b0, pat(100 + di)); di++; end
      else          begin push_exp(1'b1, 1'b0, pat(200 + si)); si++; end
      turn_dbg = !turn_dbg;
    end
    @(posedge clk); #1;
    idle_all();
    drain();
  endtask

  task automatic test_lock_hold();
    int di = 0;
    int si = 0;
    int act_dbg = 0;
    int act_sys = 0;
    int run = 0;
    int max_run = 0;
    logic exp_dbg;
    apply_reset();
    for (int k = 0; k < 42; k++) begin
      @(posedge clk); #1;
      set_dbg(1'b1, 1'b0, BASE + 32'(4 * (300 + di)), 4'hF, 32'h0, 1'b1);
      set_sys(1'b1, 1'b0, BASE + 32'(4 * (400 + si)), 4'hF, 32'h0, 1'b0);
      exp_dbg = ((k % 17) != 16);
      @(negedge clk);
      checks++;
      if (dbg_gnt !== exp_dbg || sys_gnt !== !exp_dbg) begin
        errors++;
        $display("FAIL lock_hold k=%0d got gnt d/s=%b/%b required %b/%b", k, dbg_gnt, sys_gnt, exp_dbg, !exp_dbg);
      end
      if (dbg_gnt === 1'b1) act_dbg++;
      if (sys_gnt === 1'b1) begin act_sys++; run = 0; end
      else begin run++; if (run > max_run) max_run = run; end
      if (exp_dbg) begin push_exp(1'b0, 1'b0, pat(300 + di)); di++; end
      else         begin push_exp(1'b1, 1'b0, pat(400 + si)); si++; end
    end
    checks++;
    if (act_dbg !== 40 || act_sys !== 2 || max_run !== 16) begin
      errors++;
      $display("FAIL lock_totals got dbg=%0d sys=%0d max_wait=%0d required 40 2 16", act_dbg, act_sys, max_run);
    end
    @(posedge clk); #1;
    idle_all();
    drain();
  endtask

  task automatic test_decode_err();
    logic [31:0] addrs [6] = '{32'h1C00_1000, 32'h1BFF_FFFC, 32'h1C00_0002,
                               32'h1C00_0FFC, 32'h1C00_0003, 32'hFFFF_FFFC};
    logic        errs  [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    logic        wes   [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic        on_sys;
    for (int i = 0; i < 6; i++) begin
      on_sys = (i % 2) == 1;
      @(posedge clk); #1;
      idle_all();
      if (on_sys) set_sys(1'b1, wes[i], addrs[i], 4'hF, 32'h5555_AAAA, 1'b0);
      else        set_dbg(1'b1, wes[i], addrs[i], 4'hF, 32'h5555_AAAA, 1'b0);
      @(negedge clk);
      checks++;
      if (dbg_gnt !== !on_sys || sys_gnt !== on_sys || mem_req !== !errs[i] ||
          (!errs[i] && mem_addr !== 10'd1023)) begin
        errors++;
        $display("FAIL decode addr=%h got gnt d/s=%b/%b mem_req=%b mem_addr=%h required sys=%b mem_req=%b",
                 addrs[i], dbg_gnt, sys_gnt, mem_req, mem_addr, on_sys, !errs[i]);
      end
      push_exp(on_sys, errs[i], errs[i] ? 32'h0 : pat(1023));
    end
    @(posedge clk); #1;
    idle_all();
    drain();
  endtask

  task automatic test_byte_enable();
    logic [31:0] wd [3] = '{32'hFFFF_FFFF, 32'h1234_5678, 32'h0};
    logic [3:0]  be [3] = '{4'hF, 4'b0011, 4'hF};
    logic        we [3] = '{1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      set_sys(1'b1, we[i], BASE + 32'(4 * 50), be[i], wd[i], 1'b0);
      @(negedge clk);
      checks++;
      if (sys_gnt !== 1'b1 || dbg_gnt !== 1'b0 || mem_req !== 1'b1 || mem_we !== we[i] ||
          mem_be !== be[i] || mem_addr !== 10'd50) begin
        errors++;
        $display("FAIL be_issue i=%0d got gnt=%b req=%b we=%b be=%b addr=%0d required 1 1 %b %b 50",
                 i, sys_gnt, mem_req, mem_we, mem_be, mem_addr, we[i], be[i]);
      end
      push_exp(1'b1, 1'b0, we[i] ? 32'h0 : 32'hFFFF_5678);
    end
    @(posedge clk); #1;
    set_sys(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0);
    set_dbg(1'b1, 1'b0, BASE + 32'(4 * 50), 4'hF, 32'h0, 1'b0);
    @(negedge clk);
    push_exp(1'b0, 1'b0, 32'hFFFF_5678);
    @(posedge clk); #1;
    idle_all();
    drain();
  endtask

  task automatic test_reset_mid_burst();
    @(posedge clk); #1;
    set_sys(1'b1, 1'b0, BASE + 32'(4 * 60), 4'hF, 32'h0, 1'b1);
    @(negedge clk);
    checks++;
    if (sys_gnt !== 1'b1 || mem_req !== 1'b1) begin
      errors++;
      $display("FAIL abort_grant got gnt=%b req=%b required 1 1", sys_gnt, mem_req);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    idle_all();
    @(negedge clk);
    checks++;
    if (dbg_rvalid !== 1'b0 || sys_rvalid !== 1'b0 || sys_err !== 1'b0 || sys_rdata !== 32'h0) begin
      errors++;
      $display("FAIL abort_rvalid got rv d/s=%b/%b err=%b rdata=%h required 0", dbg_rvalid, sys_rvalid, sys_err, sys_rdata);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    set_dbg(1'b1, 1'b0, BASE + 32'(4 * 70), 4'hF, 32'h0, 1'b0);
    set_sys(1'b1, 1'b0, BASE + 32'(4 * 71), 4'hF, 32'h0, 1'b0);
    @(negedge clk);
    checks++;
    if (dbg_gnt !== 1'b1 || sys_gnt !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_rr got gnt d/s=%b/%b required 1/0", dbg_gnt, sys_gnt);
    end
    push_exp(1'b0, 1'b0, pat(70));
    @(posedge clk); #1;
    set_dbg(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0);
    @(negedge clk);
    checks++;
    if (sys_gnt !== 1'b1 || dbg_gnt !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_sys got gnt d/s=%b/%b required 0/1", dbg_gnt, sys_gnt);
    end
    push_exp(1'b1, 1'b0, pat(71));
    @(posedge clk); #1;
    idle_all();
    drain();
  endtask

  initial begin
    rst = 1'b1;
    idle_all();
    @(posedge clk); #1;
    test_reset();
    test_dbg_write_read();
    test_alternate();
    test_lock_hold();
    test_decode_err();
    test_byte_enable();
    test_reset_mid_burst();
    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got no completion required finish");
    $fatal(1, "timeout");
  end

endmodule
